// File: rtl/pc_lut_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pc_lut_loader : byte-stream writer for the branch-target lookup table      |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module pc_lut_loader #(
    parameter int D  = 12,
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] how_high,
    output logic [D-1:0]  target,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IW-1:0] c_LAST = IW'(N - 1);

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [7:0]      lo_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            rdy_q;
    logic [D-1:0]    table_q [N];

    logic            w_ext_ok;
    logic [D-1:0]    w_entry_d;

    // Every high-byte bit above the entry's MSB must replicate that MSB.
    always_comb begin
        w_ext_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > D - 9 && in_data[i] != in_data[D-9]) begin
                w_ext_ok = 1'b0;
            end
        end
    end

    assign w_entry_d = {in_data[D-9:0], lo_q};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_LO;
                        ptr_q   <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        rdy_q   <= 1'b1;
                    end
                end
                S_LO: begin
                    if (in_valid) begin
                        lo_q    <= in_data;
                        state_q <= S_HI;
                    end
                end
                S_HI: begin
                    if (in_valid) begin
                        if (w_ext_ok) begin
                            table_q[ptr_q] <= w_entry_d;
                            if (ptr_q == c_LAST) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                rdy_q   <= 1'b0;
                            end else begin
                                ptr_q   <= ptr_q + 1'b1;
                                state_q <= S_LO;
                            end
                        end else begin
                            // Malformed entry aborts the load; earlier entries stay.
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            rdy_q   <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready = rdy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign target   = table_q[how_high];

endmodule
`default_nettype wire

// File: tb/tb_pc_lut_loader.sv
`default_nettype none
// Self-checking bench for pc_lut_loader: vector table plus directed corner sequences.
module tb_pc_lut_loader;

    localparam int D  = 12;
    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] how_high;
    logic [D-1:0]  target;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0]   lo;
        logic [7:0]   hi;
        logic [D-1:0] exp;
    } vec_t;

    vec_t vecs [N];

    pc_lut_loader #(.D(D), .N(N), .IW(IW)) dut (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .how_high (how_high),
        .target   (target),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        w        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", w);
        end
        tick();
        in_valid = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_table(input string name);
        for (int i = 0; i < N; i++) begin
            how_high = IW'(i);
            #1;
            chk(name, {20'd0, target}, {20'd0, vecs[i].exp});
        end
    endtask

    initial begin
        int c0;
        vecs[0] = '{8'h01, 8'h00, 12'h001};
        vecs[1] = '{8'hFF, 8'hFF, 12'hFFF};
        vecs[2] = '{8'h18, 8'h00, 12'h018};
        vecs[3] = '{8'hE4, 8'hFF, 12'hFE4};
        vecs[4] = '{8'h7C, 8'h00, 12'h07C};
        vecs[5] = '{8'h80, 8'hFF, 12'hF80};
        vecs[6] = '{8'h95, 8'h00, 12'h095};
        vecs[7] = '{8'h63, 8'hFF, 12'hF63};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        how_high = '0;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_target", {20'd0, target}, 32'd0);
        rst_n = 1'b1;
        tick();

        // valid in IDLE is ignored
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
        chk("idle_ignore_busy", {31'd0, busy}, 32'd0);

        // Full load without gaps
        c0 = cyc;
        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < N; i++) begin
            send(vecs[i].lo);
            if (i == N - 1) chk("done_early", {31'd0, done}, 32'd0);
            send(vecs[i].hi);
        end
        chk("done_cycle", cyc - c0, 32'd17);
        chk("done_set", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_ready", {31'd0, in_ready}, 32'd0);
        check_table("full_load");

        // Gapped load with a start pulse during HI
        pulse_start();
        chk("reload_done_clr", {31'd0, done}, 32'd0);
        for (int i = 0; i < N; i++) begin
            for (int h = 0; h < 2; h++) begin
                send(h == 0 ? vecs[i].lo : vecs[i].hi);
                for (int g = 0; g < 3; g++) begin
                    in_data = 8'h5A + 8'(g);
                    start   = (i == 3 && h == 0 && g == 1);
                    if (!(i == N - 1 && h == 1)) chk("gap_busy", {31'd0, busy}, 32'd1);
                    tick();
                    start = 1'b0;
                end
            end
        end
        chk("gap_done", {31'd0, done}, 32'd1);
        check_table("gap_load");

        // Same-cycle read of the entry being written
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            send(vecs[i].lo);
            send(vecs[i].hi);
        end
        send(8'hAB);
        how_high   = 3'd2;
        in_data    = 8'h00;
        in_valid   = 1'b1;
        #1;
        chk("same_cycle_old", {20'd0, target}, 32'h018);
        tick();
        in_valid = 1'b0;
        chk("same_cycle_new", {20'd0, target}, 32'h0AB);
        for (int i = 3; i < N; i++) begin
            send(vecs[i].lo);
            send(vecs[i].hi);
        end
        chk("same_cycle_done", {31'd0, done}, 32'd1);

        // Second image of zeros
        pulse_start();
        chk("zero_done_clr", {31'd0, done}, 32'd0);
        for (int i = 0; i < 2 * N; i++) send(8'h00);
        chk("zero_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < N; i++) begin
            how_high = IW'(i);
            #1;
            chk("zero_table", {20'd0, target}, 32'd0);
        end

        // Sign-extension error
        pulse_start();
        send(8'h10);
        send(8'h00);
        send(8'h22);
        send(8'h5F);
        chk("err_set", {31'd0, err}, 32'd1);
        chk("err_busy", {31'd0, busy}, 32'd0);
        chk("err_ready", {31'd0, in_ready}, 32'd0);
        chk("err_done", {31'd0, done}, 32'd0);
        how_high = 3'd0;
        #1;
        chk("err_tab0", {20'd0, target}, 32'h010);
        how_high = 3'd1;
        #1;
        chk("err_tab1", {20'd0, target}, 32'h000);
        tick();
        chk("err_sticky", {31'd0, err}, 32'd1);
        pulse_start();
        chk("err_clear", {31'd0, err}, 32'd0);
        chk("err_restart_busy", {31'd0, busy}, 32'd1);

        // Reset after five accepted bytes
        send(vecs[0].lo);
        send(vecs[0].hi);
        send(vecs[1].lo);
        send(vecs[1].hi);
        send(vecs[2].lo);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < N; i++) begin
            how_high = IW'(i);
            #1;
            chk("rst_table", {20'd0, target}, 32'd0);
        end
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
